// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between fetch and load/store requesters.
// One access in flight at a time; data has priority unless fetch has been starved.
module mem_port_arbiter #(
    parameter int unsigned W_ADDR     = 32,
    parameter int unsigned W_DATA     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester
    input  logic              if_req,
    input  logic [W_ADDR-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [W_DATA-1:0] if_rdata,
    // load/store requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [W_ADDR-1:0] d_addr,
    input  logic [W_DATA-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [W_DATA-1:0] d_rdata,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [W_ADDR-1:0] mem_addr,
    output logic [W_DATA-1:0] mem_wdata,
    input  logic [W_DATA-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               owner_data_q, owner_data_d;

    logic               fetch_win;
    logic               data_win;
    logic               starved;
    logic               lat_done;

    assign starved  = (starve_q == STV_W'(STARVE_MAX));
    assign lat_done = (state_q == StBusy) && (lat_cnt_q == LAT_W'(MEM_LAT));

    // Winner selection; suppressed while reset is held so every output reads 0.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if ((state_q == StIdle) && !rst) begin
            if (if_req && d_req) begin
                if (starved) begin
                    fetch_win = 1'b1;
                end else begin
                    data_win = 1'b1;
                end
            end else begin
                fetch_win = if_req;
                data_win  = d_req;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_d     = starve_q;
        owner_data_d = owner_data_q;
        case (state_q)
            StIdle: begin
                if (fetch_win || data_win) begin
                    state_d      = StBusy;
                    lat_cnt_d    = LAT_W'(1);
                    owner_data_d = data_win;
                    if (fetch_win) begin
                        starve_d = '0;
                    end else if (if_req && !starved) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                end
            end
            StBusy: begin
                if (lat_done) begin
                    state_d   = StIdle;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                lat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            lat_cnt_q    <= '0;
            starve_q     <= '0;
            owner_data_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_q     <= starve_d;
            owner_data_q <= owner_data_d;
        end
    end

    always_comb begin
        if_gnt    = fetch_win;
        d_gnt     = data_win;
        mem_en    = fetch_win | data_win;
        mem_we    = data_win & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (data_win) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (fetch_win) begin
            mem_addr = if_addr;
        end
        // Response pulse goes to whoever owns the in-flight access; stores get it as an ack.
        if_rvalid = lat_done & ~owner_data_q;
        d_rvalid  = lat_done & owner_data_q;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and 3) share one stimulus stream and are
// checked every cycle against a timeline model, plus directed scenarios with fixed expectations.
module tb_mem_port_arbiter;

    localparam int N    = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

    logic        if_gnt    [N];
    logic        if_rvalid [N];
    logic [31:0] if_rdata  [N];
    logic        d_gnt     [N];
    logic        d_rvalid  [N];
    logic [31:0] d_rdata   [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic        busy      [N];

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles until the response (0 = free), who owns it, lost-arbitration count.
    int wait_m     [N];
    bit own_data_m [N];
    int starve_m   [N];
    int win_m      [N];  // 0 none, 1 fetch, 2 data

    for (genvar g = 0; g < N; g++) begin : gen_dut
        mem_port_arbiter #(
            .W_ADDR     (32),
            .W_DATA     (32),
            .MEM_LAT    ((g == 0) ? 1 : 3),
            .STARVE_MAX (SMAX)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata),
            .busy      (busy[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            wait_m[i]     = 0;
            own_data_m[i] = 1'b1;
            starve_m[i]   = 0;
            win_m[i]      = 0;
        end
    endtask

    task automatic check_now();
        for (int i = 0; i < N; i++) begin
            bit    rv;
            string p;
            p = $sformatf("u%0d@%0t", i, $time);
            win_m[i] = 0;
            if (wait_m[i] == 0) begin
                if (if_req && d_req) win_m[i] = (starve_m[i] >= SMAX) ? 1 : 2;
                else if (if_req)     win_m[i] = 1;
                else if (d_req)      win_m[i] = 2;
            end
            rv = (wait_m[i] == 1);
            chkb({p, " if_gnt"}, if_gnt[i], win_m[i] == 1);
            chkb({p, " d_gnt"}, d_gnt[i], win_m[i] == 2);
            chkb({p, " mem_en"}, mem_en[i], win_m[i] != 0);
            chkb({p, " mem_we"}, mem_we[i], (win_m[i] == 2) && d_we);
            if (win_m[i] != 0) begin
                chk({p, " mem_addr"}, mem_addr[i], (win_m[i] == 1) ? if_addr : d_addr);
                chk({p, " mem_wdata"}, mem_wdata[i], (win_m[i] == 1) ? 32'h0 : d_wdata);
            end
            chkb({p, " busy"}, busy[i], wait_m[i] != 0);
            chkb({p, " if_rvalid"}, if_rvalid[i], rv && !own_data_m[i]);
            chkb({p, " d_rvalid"}, d_rvalid[i], rv && own_data_m[i]);
            chk({p, " if_rdata"}, if_rdata[i], (rv && !own_data_m[i]) ? mem_rdata : 32'h0);
            chk({p, " d_rdata"}, d_rdata[i], (rv && own_data_m[i]) ? mem_rdata : 32'h0);
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < N; i++) begin
            if (wait_m[i] > 0) wait_m[i]--;
            if (win_m[i] == 1) begin
                wait_m[i]     = lat_of(i);
                own_data_m[i] = 1'b0;
                starve_m[i]   = 0;
            end else if (win_m[i] == 2) begin
                wait_m[i]     = lat_of(i);
                own_data_m[i] = 1'b1;
                if (if_req && starve_m[i] < SMAX) starve_m[i]++;
            end
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge, return just after it.
    task automatic cycle();
        @(negedge clk);
        check_now();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            string p;
            p = $sformatf("%s u%0d", tag, i);
            chkb({p, " if_gnt"}, if_gnt[i], 1'b0);
            chkb({p, " d_gnt"}, d_gnt[i], 1'b0);
            chkb({p, " mem_en"}, mem_en[i], 1'b0);
            chkb({p, " mem_we"}, mem_we[i], 1'b0);
            chk({p, " mem_addr"}, mem_addr[i], 32'h0);
            chk({p, " mem_wdata"}, mem_wdata[i], 32'h0);
            chkb({p, " if_rvalid"}, if_rvalid[i], 1'b0);
            chkb({p, " d_rvalid"}, d_rvalid[i], 1'b0);
            chk({p, " if_rdata"}, if_rdata[i], 32'h0);
            chk({p, " d_rdata"}, d_rdata[i], 32'h0);
            chkb({p, " busy"}, busy[i], 1'b0);
        end
    endtask

    // Reset asserted and released between clock edges; returns 3 time units after a rising edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero({tag, " immediate"});
        @(posedge clk);
        #1 chk_zero({tag, " held"});
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        string order;
        string exp_order;
        bit    got_f;

        rst       = 1'b1;
        if_req    = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        if_addr   = 32'h0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_rdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_zero("power-on reset");
        chk("reset starve", 32'(gen_dut[0].u_dut.starve_q), 32'h0);
        #2 rst = 1'b0;

        // Lone fetch, MEM_LAT=1
        if_req  = 1'b1;
        if_addr = 32'h0040_0000;
        #1;
        chkb("t2 if_gnt T", if_gnt[0], 1'b1);
        chkb("t2 mem_en T", mem_en[0], 1'b1);
        chk("t2 mem_addr T", mem_addr[0], 32'h0040_0000);
        cycle();
        if_req    = 1'b0;
        mem_rdata = 32'h2008_000A;
        #1;
        chkb("t2 if_rvalid T+1", if_rvalid[0], 1'b1);
        chk("t2 if_rdata T+1", if_rdata[0], 32'h2008_000A);
        cycle();
        #1 chkb("t2 busy T+2", busy[0], 1'b0);
        repeat (2) cycle();

        // Simultaneous fetch and load: data first
        if_req    = 1'b1;
        if_addr   = 32'h0040_0004;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h1001_0004;
        mem_rdata = 32'h0;
        #1;
        chkb("t3 d_gnt T", d_gnt[0], 1'b1);
        chkb("t3 if_gnt T", if_gnt[0], 1'b0);
        cycle();
        d_req     = 1'b0;
        mem_rdata = 32'h1234_5678;
        #1;
        chkb("t3 d_rvalid T+1", d_rvalid[0], 1'b1);
        chkb("t3 if_rvalid T+1", if_rvalid[0], 1'b0);
        chk("t3 d_rdata T+1", d_rdata[0], 32'h1234_5678);
        cycle();
        #1 chkb("t3 if_gnt T+2", if_gnt[0], 1'b1);
        cycle();
        if_req    = 1'b0;
        mem_rdata = 32'h8C88_0004;
        #1;
        chkb("t3 if_rvalid T+3", if_rvalid[0], 1'b1);
        chkb("t3 d_rvalid T+3", d_rvalid[0], 1'b0);
        cycle();
        repeat (3) cycle();

        // Starvation: both held high from a clean reset
        async_reset("t4 reset");
        if_req  = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h1001_0008;
        if_addr = 32'h0040_0010;
        order   = "";
        for (int c = 0; c < 12; c++) begin
            #1;
            got_f = if_gnt[0];
            if (got_f) begin
                order = {order, "f"};
                chk("t4 starve before fetch", 32'(gen_dut[0].u_dut.starve_q), 32'd4);
            end else if (d_gnt[0]) begin
                order = {order, "d"};
            end
            cycle();
            if (got_f) chk("t4 starve after fetch", 32'(gen_dut[0].u_dut.starve_q), 32'h0);
        end
        exp_order = "ddddfd";
        checks++;
        assert (order == exp_order) else begin
            failures++;
            $error("FAIL t4 grant order: got %s expected %s", order, exp_order);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (4) cycle();

        // Store on both latencies
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1001_0000;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        for (int i = 0; i < N; i++) begin
            chkb($sformatf("t5 u%0d mem_en T", i), mem_en[i], 1'b1);
            chkb($sformatf("t5 u%0d mem_we T", i), mem_we[i], 1'b1);
            chk($sformatf("t5 u%0d mem_addr T", i), mem_addr[i], 32'h1001_0000);
            chk($sformatf("t5 u%0d mem_wdata T", i), mem_wdata[i], 32'hDEAD_BEEF);
        end
        cycle();
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_wdata = 32'h0;
        #1;
        chkb("t5 mem_en T+1", mem_en[0], 1'b0);
        chkb("t5 mem_we T+1", mem_we[0], 1'b0);
        chkb("t5 u0 d_rvalid T+1", d_rvalid[0], 1'b1);
        chkb("t5 u1 d_rvalid T+1", d_rvalid[1], 1'b0);
        cycle();
        #1 chkb("t5 u1 d_rvalid T+2", d_rvalid[1], 1'b0);
        cycle();
        #1;
        chkb("t5 u1 d_rvalid T+3", d_rvalid[1], 1'b1);
        chkb("t5 u1 busy T+3", busy[1], 1'b1);
        cycle();
        #1 chkb("t5 u1 busy T+4", busy[1], 1'b0);
        repeat (2) cycle();

        // Reset in the middle of a fetch abandons it
        if_req  = 1'b1;
        if_addr = 32'h0040_0020;
        #1 chkb("t6 u1 if_gnt T", if_gnt[1], 1'b1);
        cycle();
        if_req = 1'b0;
        async_reset("t6 reset");
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1001_0010;
        #1;
        chkb("t6 u0 d_gnt after reset", d_gnt[0], 1'b1);
        chkb("t6 u1 d_gnt after reset", d_gnt[1], 1'b1);
        cycle();
        d_req = 1'b0;
        repeat (5) cycle();

        // Randomized traffic with held requests, withdrawals and occasional resets
        for (int c = 0; c < 800; c++) begin
            if (!if_req || win_m[0] == 1 || $urandom_range(15) == 0) begin
                if_req  = 1'($urandom_range(1));
                if_addr = $urandom;
            end
            if (!d_req || win_m[0] == 2 || $urandom_range(15) == 0) begin
                d_req   = 1'($urandom_range(1));
                d_we    = 1'($urandom_range(1));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            if ($urandom_range(199) == 0) async_reset("rnd reset");
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
